// File: rtl/iic_byte_ctrl_if.sv
// iic_byte_ctrl_if: host-side command/response channel of the IIC byte sequencer.
// Command: I_cmd_valid/O_cmd_ready handshake carrying start, stop, read, nack and wdata.
// Response: O_rsp_valid one-cycle pulse with O_rsp_rdata and O_rsp_nack.
interface iic_byte_ctrl_if;
  logic       I_cmd_valid;
  logic       O_cmd_ready;
  logic       I_cmd_start;
  logic       I_cmd_stop;
  logic       I_cmd_read;
  logic       I_cmd_nack;
  logic [7:0] I_cmd_wdata;
  logic       O_rsp_valid;
  logic [7:0] O_rsp_rdata;
  logic       O_rsp_nack;
  modport master (
    output I_cmd_valid, I_cmd_start, I_cmd_stop, I_cmd_read, I_cmd_nack, I_cmd_wdata,
    input  O_cmd_ready, O_rsp_valid, O_rsp_rdata, O_rsp_nack
  );
  modport slave (
    input  I_cmd_valid, I_cmd_start, I_cmd_stop, I_cmd_read, I_cmd_nack, I_cmd_wdata,
    output O_cmd_ready, O_rsp_valid, O_rsp_rdata, O_rsp_nack
  );
endinterface

// File: rtl/iic_byte_ctrl.sv
// iic_byte_ctrl: expands one host byte command into IIC bit-engine commands.
// Ports:
//   I_clk, I_rst          clock, synchronous active-high reset
//   host                  command/response channel (iic_byte_ctrl_if.slave)
//   O_bus_held            set by a consumed S/SR, cleared by a consumed P
//   O_dc, O_rw, O_data    engine command (000 = NOP), held until consumed
//   I_next                engine idle; a non-NOP command is consumed when high
//   I_rdata               SDA bit sampled by the engine, valid when I_next returns high
module iic_byte_ctrl #(
  parameter bit AUTO_STOP_NACK = 1'b1
) (
  input  logic     I_clk,
  input  logic     I_rst,
  iic_byte_ctrl_if.slave host,
  output logic     O_bus_held,
  output logic     O_dc,
  output logic     O_rw,
  output logic     O_data,
  input  logic     I_next,
  input  logic     I_rdata
);
  typedef enum logic [3:0] {
    IDLE, START, W_START, BIT, W_BIT, ACK, W_ACK, STOP, W_STOP, RESP
  } state_t;
  state_t     state, state_nx;
  logic [2:0] idx;
  logic       stop_r, read_r, nack_r;
  logic [7:0] wdata_r, shift_r;
  logic [2:0] cmd;
  logic       accept, go_stop;
  assign accept = host.I_cmd_valid && state == IDLE;
  // On a write, the slave's ACK bit is I_rdata in the cycle W_ACK completes.
  assign go_stop = stop_r || (AUTO_STOP_NACK && !read_r && I_rdata);
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      state            <= IDLE;
      idx              <= 3'd0;
      stop_r           <= 1'b0;
      read_r           <= 1'b0;
      nack_r           <= 1'b0;
      wdata_r          <= 8'd0;
      shift_r          <= 8'd0;
      O_bus_held       <= 1'b0;
      host.O_rsp_valid <= 1'b0;
      host.O_rsp_rdata <= 8'd0;
      host.O_rsp_nack  <= 1'b0;
    end else begin
      state            <= state_nx;
      host.O_rsp_valid <= state == RESP;
      if (accept) begin
        stop_r  <= host.I_cmd_stop;
        read_r  <= host.I_cmd_read;
        nack_r  <= host.I_cmd_nack;
        wdata_r <= host.I_cmd_wdata;
        idx     <= 3'd7;
      end
      if (state == START && I_next) O_bus_held <= 1'b1;
      if (state == STOP && I_next) O_bus_held <= 1'b0;
      if (state == W_BIT && I_next) begin
        idx <= idx - 3'd1;
        if (read_r) shift_r <= {shift_r[6:0], I_rdata};
      end
      if (state == W_ACK && I_next && !read_r) nack_r <= I_rdata;
      if (state == RESP) begin
        host.O_rsp_nack <= nack_r;
        if (read_r) host.O_rsp_rdata <= shift_r;
      end
    end
  end
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    state_nx = accept ? ((host.I_cmd_start || !O_bus_held) ? START : BIT) : IDLE;
      START:   state_nx = I_next ? W_START : START;
      W_START: state_nx = I_next ? BIT : W_START;
      BIT:     state_nx = I_next ? W_BIT : BIT;
      W_BIT:   state_nx = I_next ? ((idx == 3'd0) ? ACK : BIT) : W_BIT;
      ACK:     state_nx = I_next ? W_ACK : ACK;
      W_ACK:   state_nx = I_next ? (go_stop ? STOP : RESP) : W_ACK;
      STOP:    state_nx = I_next ? W_STOP : STOP;
      W_STOP:  state_nx = I_next ? RESP : W_STOP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_comb begin
    cmd = 3'b000;
    unique case (state)
      START:   cmd = O_bus_held ? 3'b011 : 3'b001;
      BIT:     cmd = read_r ? 3'b110 : {2'b10, wdata_r[idx]};
      ACK:     cmd = {2'b10, read_r ? nack_r : 1'b1};
      STOP:    cmd = 3'b010;
      default: cmd = 3'b000;
    endcase
    host.O_cmd_ready = state == IDLE;
  end
  assign {O_dc, O_rw, O_data} = cmd;
endmodule

// File: doc/iic_byte_ctrl.md
Name: iic_byte_ctrl

Overview:
Byte-level transaction sequencer for the IIC bit engine. It accepts one byte command at a time from a host: optional START, 8 data bits MSB first (write or read), an ACK bit, and an optional STOP. It expands each command into the engine's {dc,rw,data} bit commands using the engine's next handshake, and returns read data and ACK status. It sits between the host/register logic and iic_master, and is the only driver of the engine command inputs.

Parameters:
AUTO_STOP_NACK, 1, when 1, a NACK received on a write byte forces STOP even if I_cmd_stop=0.

Ports:
I_clk  in  1  system clock
I_rst  in  1  synchronous reset, active-high
I_cmd_valid  in  1  host command valid
O_cmd_ready  out  1  controller idle; command accepted on I_cmd_valid & O_cmd_ready
I_cmd_start  in  1  issue START (or repeated START) before the byte
I_cmd_stop  in  1  issue STOP after the ACK bit
I_cmd_read  in  1  1 = receive byte, 0 = send I_cmd_wdata
I_cmd_nack  in  1  read only: ACK value driven by master (0 = ACK, 1 = NACK)
I_cmd_wdata  in  8  write byte
O_rsp_valid  out  1  one-cycle pulse: transaction complete
O_rsp_rdata  out  8  received byte; held until next O_rsp_valid
O_rsp_nack  out  1  sampled ACK bit (write: slave ACK; read: echo of I_cmd_nack)
O_bus_held  out  1  1 between a consumed S/SR and a consumed P
O_dc, O_rw, O_data  out  1 each  engine command
I_next  in  1  engine idle/accepting
I_rdata  in  1  engine sampled SDA bit

Behaviour:
- Reset (sync, I_rst=1 at edge): state IDLE, O_dc/O_rw/O_data=000 (NOP), O_cmd_ready=1, O_rsp_valid=0, O_rsp_rdata=0, O_rsp_nack=0, O_bus_held=0, bit counter=0. The engine is not reset by this block. Reset mid-transaction abandons the transaction without issuing STOP.
- Engine handshake: a non-NOP command is consumed at a clock edge where I_next=1. Each command is held stable until it is consumed. NOP is driven in every non-issue state. I_next is 0 on the cycle after consumption and returns to 1 when the engine is idle. I_rdata is valid in that first I_next=1 cycle.
- Command codes: S=001, SR=011, P=010, SEND0=100, SEND1=101, RECV=110.
- Command acceptance: only in IDLE. The controller latches start, stop, read, nack and wdata, and O_cmd_ready drops the next cycle. If O_bus_held=0 and I_cmd_start=0, START is forced.
- FSM states: IDLE -> START -> W_START -> BIT -> W_BIT -> ACK -> W_ACK -> [STOP -> W_STOP] -> RESP -> IDLE.
  - START: drives SR if O_bus_held=1, else S. On consumption, O_bus_held is set and the FSM goes to W_START.
  - W_*: waits for I_next=1, then advances.
  - BIT: bit index i counts 7 down to 0. A write drives SEND0 or SEND1 from wdata[i]; a read drives RECV. In W_BIT a read shifts I_rdata into rdata LSB. After i=0 the FSM goes to ACK, otherwise back to BIT with i-1.
  - ACK: a write drives SEND1 (SDA released) and W_ACK captures I_rdata into nack. A read drives SEND0 if I_cmd_nack=0, else SEND1, and nack is set to I_cmd_nack.
  - After W_ACK, the FSM goes to STOP if stop=1, or if AUTO_STOP_NACK=1 & write & nack=1. Otherwise it goes to RESP.
  - STOP: drives P. On consumption, O_bus_held is cleared.
  - RESP: registers O_rsp_valid=1 for exactly one cycle and updates O_rsp_rdata/O_rsp_nack. The FSM is then in IDLE with O_cmd_ready=1 on the following cycle.
- Timing with the engine always ready: START and STOP each take 4 cycles from issue to the next issue. Each data/ACK bit takes 5 cycles (4 engine cycles plus 1 wait cycle).
- For a write, O_rsp_rdata is unchanged. I_cmd_valid outside IDLE is ignored.

Test Plan:
- Write 0xA5, start=1, stop=1, slave ACKs: engine sees S, then SEND1,0,1,0,0,1,0,1, then SEND1, then P. Expect O_rsp_nack=0, a single O_rsp_valid pulse, and O_bus_held=0 at the end.
- Read with start=0 following an unstopped write, nack=1, stop=1, slave drives 0x3C: engine sees no START, then 8 RECV, SEND1, P. Expect O_rsp_rdata=0x3C and O_rsp_nack=1.
- Write 0x50, stop=0, slave NACKs: with AUTO_STOP_NACK=1, P is issued and O_bus_held=0; with AUTO_STOP_NACK=0, no P and O_bus_held=1.
- Back-to-back: write (start=1, stop=0), then read (start=1): the second START is SR (011). Commands are never changed while I_next=0 after consumption. O_cmd_ready=0 throughout each transaction.
- Engine stalled (I_next held 0 for 20 cycles during a bit): the command stays stable, and no bit is dropped or duplicated.
- I_rst=1 mid-byte: the next cycle shows NOP, O_bus_held=0, O_cmd_ready=1, and no O_rsp_valid. Command with start=0 after reset: S is forced.
